// File: rtl/nw_pkg.sv
// Shared types and saturating arithmetic helpers for the linear systolic aligner.
package nw_pkg;

  typedef enum logic {NW_GLOBAL = 1'b0, SW_LOCAL = 1'b1} mode_e;

  typedef enum logic [1:0] {LOAD, STREAM, DRAIN, RESULT} state_e;

  // Clamp a wide value into the signed range of a w-bit score.
  function automatic int sat_clip(input longint v, input int unsigned w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic int sat_add(input int a, input int b, input int unsigned w);
    return sat_clip(longint'(a) + longint'(b), w);
  endfunction

  function automatic int sat_mul(input int a, input int k, input int unsigned w);
    return sat_clip(longint'(a) * longint'(k), w);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nw_pe.sv
// One processing element: holds a query char and computes one DP row cell per valid beat.
module nw_pe
  import nw_pkg::*;
#(
  parameter int unsigned C_WIDTH = 2,
  parameter int unsigned S_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init,
  input  logic signed [S_WIDTH-1:0] d_init,
  input  logic signed [S_WIDTH-1:0] l_init,
  input  logic                      q_load,
  input  logic [C_WIDTH-1:0]        q_char,
  input  mode_e                     mode,
  input  logic signed [S_WIDTH-1:0] match,
  input  logic signed [S_WIDTH-1:0] mismatch,
  input  logic signed [S_WIDTH-1:0] gap,
  input  logic                      in_valid,
  input  logic [C_WIDTH-1:0]        in_char,
  input  logic signed [S_WIDTH-1:0] in_h,
  input  logic                      in_last,
  input  logic signed [S_WIDTH-1:0] in_max,
  output logic                      out_valid,
  output logic [C_WIDTH-1:0]        out_char,
  output logic signed [S_WIDTH-1:0] out_h,
  output logic                      out_last,
  output logic signed [S_WIDTH-1:0] out_max
);

  logic [C_WIDTH-1:0]        q_q;
  logic signed [S_WIDTH-1:0] d_q;
  logic signed [S_WIDTH-1:0] l_q;
  logic signed [S_WIDTH-1:0] sub_c;
  logic signed [S_WIDTH-1:0] h_c;
  logic signed [S_WIDTH-1:0] max_c;
  int diag_i;
  int gap_i;
  int h_i;

  // Cell recurrence: diagonal substitution vs. best of top/left plus indel.
  always_comb begin
    sub_c  = (in_char == q_q) ? match : mismatch;
    diag_i = sat_add(int'(d_q), int'(sub_c), S_WIDTH);
    gap_i  = sat_add(max_i(int'(in_h), int'(l_q)), int'(gap), S_WIDTH);
    h_i    = max_i(diag_i, gap_i);
    if (mode == SW_LOCAL) h_i = max_i(h_i, 0);
    h_c    = S_WIDTH'(h_i);
    max_c  = S_WIDTH'(max_i(int'(in_max), h_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      d_q       <= '0;
      l_q       <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
      out_h     <= '0;
      out_last  <= 1'b0;
      out_max   <= '0;
    end else begin
      if (q_load) q_q <= q_char;
      if (init) begin
        d_q       <= d_init;
        l_q       <= l_init;
        out_valid <= 1'b0;
      end else if (in_valid) begin
        d_q       <= in_h;
        l_q       <= h_c;
        out_valid <= 1'b1;
        out_char  <= in_char;
        out_h     <= h_c;
        out_last  <= in_last;
        out_max   <= max_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nw_linear_array.sv
// Linear systolic NW/SW aligner: query loaded into a PE chain, reference streamed through it.
module nw_linear_array
  import nw_pkg::*;
#(
  parameter int unsigned Q_LEN   = 16,
  parameter int unsigned C_WIDTH = 2,
  parameter int unsigned S_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_mode,
  input  logic signed [S_WIDTH-1:0] cfg_match,
  input  logic signed [S_WIDTH-1:0] cfg_mismatch,
  input  logic signed [S_WIDTH-1:0] cfg_gap,
  input  logic                      q_valid,
  output logic                      q_ready,
  input  logic [C_WIDTH-1:0]        q_char,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic [C_WIDTH-1:0]        r_char,
  input  logic                      r_last,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [S_WIDTH-1:0] res_score
);

  localparam int unsigned CNT_W = $clog2(Q_LEN);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  mode_e                     mode_q;
  logic signed [S_WIDTH-1:0] match_q, mismatch_q, gap_q, top_q, smax_q;
  logic                      q_acc, r_acc, res_acc, load_done, drain_hit;

  logic                      v_a [Q_LEN+1];
  logic [C_WIDTH-1:0]        c_a [Q_LEN+1];
  logic signed [S_WIDTH-1:0] h_a [Q_LEN+1];
  logic                      l_a [Q_LEN+1];
  logic signed [S_WIDTH-1:0] m_a [Q_LEN+1];

  assign q_acc     = q_valid && q_ready;
  assign r_acc     = r_valid && r_ready;
  assign res_acc   = res_valid && res_ready;
  assign load_done = q_acc && (cnt_q == CNT_W'(Q_LEN - 1));
  assign drain_hit = v_a[Q_LEN] && l_a[Q_LEN];

  // PE 0 inputs: accepted reference beat plus the top boundary row.
  assign v_a[0] = r_acc;
  assign c_a[0] = r_char;
  assign h_a[0] = (mode_q == SW_LOCAL) ? '0 : top_q;
  assign l_a[0] = r_last;
  assign m_a[0] = '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done) state_d = STREAM;
      STREAM:  if (r_acc && r_last) state_d = DRAIN;
      DRAIN:   if (drain_hit) state_d = RESULT;
      RESULT:  if (res_acc) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      q_ready   <= 1'b1;
      r_ready   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_ready   <= (state_d == LOAD);
      r_ready   <= (state_d == STREAM);
      res_valid <= (state_d == RESULT);
    end
  end

  // Load counter, job config, top boundary generator, running local max and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      mode_q     <= NW_GLOBAL;
      match_q    <= '0;
      mismatch_q <= '0;
      gap_q      <= '0;
      top_q      <= '0;
      smax_q     <= '0;
      res_score  <= '0;
    end else begin
      if (q_acc) cnt_q <= load_done ? '0 : cnt_q + CNT_W'(1);
      if (q_acc && cnt_q == '0) begin
        mode_q     <= mode_e'(cfg_mode);
        match_q    <= cfg_match;
        mismatch_q <= cfg_mismatch;
        gap_q      <= cfg_gap;
      end
      if (load_done) top_q <= gap_q;
      else if (r_acc) top_q <= S_WIDTH'(sat_add(int'(top_q), int'(gap_q), S_WIDTH));
      if (load_done) smax_q <= '0;
      else if (v_a[Q_LEN]) smax_q <= S_WIDTH'(max_i(int'(smax_q), int'(m_a[Q_LEN])));
      if (drain_hit)
        res_score <= (mode_q == SW_LOCAL) ? S_WIDTH'(max_i(int'(smax_q), int'(m_a[Q_LEN])))
                                          : h_a[Q_LEN];
    end
  end

  for (genvar gi = 0; gi < Q_LEN; gi++) begin : g_pe
    logic signed [S_WIDTH-1:0] d_init, l_init;
    // Left column boundary: H[i][-1]=(i+1)*gap, diagonal seed H[i-1][-1]=i*gap.
    assign d_init = (mode_q == SW_LOCAL) ? '0 : S_WIDTH'(sat_mul(int'(gap_q), gi, S_WIDTH));
    assign l_init = (mode_q == SW_LOCAL) ? '0 : S_WIDTH'(sat_mul(int'(gap_q), gi + 1, S_WIDTH));

    nw_pe #(.C_WIDTH(C_WIDTH), .S_WIDTH(S_WIDTH)) u_pe (
      .clk      (clk),
      .rst      (rst),
      .init     (load_done),
      .d_init   (d_init),
      .l_init   (l_init),
      .q_load   (q_acc && (cnt_q == CNT_W'(gi))),
      .q_char   (q_char),
      .mode     (mode_q),
      .match    (match_q),
      .mismatch (mismatch_q),
      .gap      (gap_q),
      .in_valid (v_a[gi]),
      .in_char  (c_a[gi]),
      .in_h     (h_a[gi]),
      .in_last  (l_a[gi]),
      .in_max   (m_a[gi]),
      .out_valid(v_a[gi+1]),
      .out_char (c_a[gi+1]),
      .out_h    (h_a[gi+1]),
      .out_last (l_a[gi+1]),
      .out_max  (m_a[gi+1])
    );
  end

endmodule
